// File: rtl/acc_cpu_seq.sv
// Fetch/decode/execute sequencer for the accumulator CPU: owns PC, IR and carry,
// drives the shared code/data RAM and the accumulator load port, and holds the ALU.
module acc_cpu_seq #(
  parameter int BITS      = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_run,
  output logic [ADDR_BITS-1:0] o_mem_addr,
  input  logic [BITS-1:0]      i_mem_rdata,
  output logic                 o_mem_we,
  output logic [BITS-1:0]      o_mem_wdata,
  output logic                 o_acc_ld,
  output logic [BITS-1:0]      o_acc_data,
  input  logic [BITS-1:0]      i_acc_data,
  input  logic                 i_acc_zero,
  output logic [ADDR_BITS-1:0] o_pc,
  output logic                 o_carry,
  output logic                 o_halted
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_LATCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [2:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] pc_q, pc_d;
  logic [BITS-1:0]      ir_q, ir_d;
  logic                 carry_q, carry_d;

  logic [3:0]           op;
  logic [ADDR_BITS-1:0] opr;
  logic [BITS-1:0]      opr_ext;
  logic [BITS:0]        sum;
  logic [BITS:0]        diff;

  assign op      = ir_q[BITS-1 -: 4];
  assign opr     = ir_q[ADDR_BITS-1:0];
  assign opr_ext = {{(BITS-ADDR_BITS){1'b0}}, opr};

  // The top bit of the widened difference is the borrow (set iff acc < mem).
  assign sum  = {1'b0, i_acc_data} + {1'b0, i_mem_rdata};
  assign diff = {1'b0, i_acc_data} - {1'b0, i_mem_rdata};

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path
    // through the case statements leaves one unassigned (which would infer a latch).
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    carry_d    = carry_q;
    o_mem_addr = pc_q;
    o_mem_we   = 1'b0;
    o_acc_ld   = 1'b0;
    o_acc_data = '0;

    case (state_q)
      S_FETCH: begin
        if (i_run) state_d = S_LATCH;
      end
      S_LATCH: begin
        ir_d    = i_mem_rdata;
        pc_d    = pc_q + ADDR_BITS'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_FETCH;
        case (op)
          OP_LDA, OP_ADD, OP_SUB: begin
            o_mem_addr = opr;
            state_d    = S_EXEC;
          end
          OP_STA: begin
            o_mem_addr = opr;
            o_mem_we   = 1'b1;
          end
          OP_JMP: pc_d = opr;
          OP_JZ: begin
            if (i_acc_zero) pc_d = opr;
          end
          OP_LDI: begin
            o_acc_ld   = 1'b1;
            o_acc_data = opr_ext;
          end
          OP_HLT:  state_d = S_HALT;
          default: ;
        endcase
      end
      S_EXEC: begin
        o_mem_addr = opr;
        o_acc_ld   = 1'b1;
        state_d    = S_FETCH;
        case (op)
          OP_ADD: begin
            o_acc_data = sum[BITS-1:0];
            carry_d    = sum[BITS];
          end
          OP_SUB: begin
            o_acc_data = diff[BITS-1:0];
            carry_d    = diff[BITS];
          end
          default: o_acc_data = i_mem_rdata;
        endcase
      end
      S_HALT:  ;
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      carry_q <= carry_d;
    end
  end

  assign o_mem_wdata = i_acc_data;
  assign o_pc        = pc_q;
  assign o_carry     = carry_q;
  assign o_halted    = (state_q == S_HALT);

endmodule
